// File: rtl/sram_arbiter.sv
// sram_arbiter: two-port arbiter and access sequencer for the external 64Kx16 asynchronous SRAM.
//
// Grants one single-word read/write request at a time and walks it through
// IDLE -> SETUP -> ACCESS (WAIT_CYCLES) -> HOLD. Every SRAM-facing output is a flop, so the
// pins never see a combinational path from the requester inputs.
//
// Parameters:
//   WAIT_CYCLES  cycles WE_n/OE_n are held low per access (1..15)
// Ports:
//   clk_100mhz, resetn             clock, asynchronous active-low reset
//   pX_req/we/addr/wdata/be        request from port X (held stable until pX_ack)
//   pX_ack                         one-cycle completion pulse (during HOLD)
//   pX_rdata                       read data, valid with ack, held until next read ack
//   busy                           high whenever the sequencer is not idle
//   sram_a, sram_d_o, sram_d_oe    address, write data and pad output enable
//   sram_d_i                       data from the pad
//   sram_ce_n/oe_n/we_n/lb_n/ub_n  active-low SRAM controls
// Build option:
//   SRAM_ARB_PRIORITY_EN           fixed priority (port 0 wins ties) instead of round-robin

module sram_arbiter #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        clk_100mhz,
  input  logic        resetn,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [15:0] p0_addr,
  input  logic [15:0] p0_wdata,
  input  logic [1:0]  p0_be,
  output logic        p0_ack,
  output logic [15:0] p0_rdata,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [15:0] p1_addr,
  input  logic [15:0] p1_wdata,
  input  logic [1:0]  p1_be,
  output logic        p1_ack,
  output logic [15:0] p1_rdata,
  output logic        busy,
  output logic [15:0] sram_a,
  output logic [15:0] sram_d_o,
  output logic        sram_d_oe,
  input  logic [15:0] sram_d_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_lb_n,
  output logic        sram_ub_n
);

  typedef enum logic [1:0] {StIdle, StSetup, StAccess, StHold} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic        port_q, port_d;
  logic [15:0] a_q, a_d;
  logic [15:0] d_o_q, d_o_d;
  logic        d_oe_q, d_oe_d;
  logic        ce_n_q, ce_n_d;
  logic        oe_n_q, oe_n_d;
  logic        we_n_q, we_n_d;
  logic        lb_n_q, lb_n_d;
  logic        ub_n_q, ub_n_d;
  logic        ack0_q, ack0_d;
  logic        ack1_q, ack1_d;
  logic [15:0] rdata0_q, rdata0_d;
  logic [15:0] rdata1_q, rdata1_d;

  // Winning port index for the current IDLE cycle (0 or 1).
  logic grant;

`ifdef SRAM_ARB_PRIORITY_EN
  assign grant = ~p0_req;
`else
  logic last_q, last_d;
  // On a tie the port that was not served last wins.
  assign grant = (p0_req && p1_req) ? ~last_q : p1_req;
`endif

  logic        sel_we;
  logic [15:0] sel_addr;
  logic [15:0] sel_wdata;
  logic [1:0]  sel_be;

  assign sel_we    = grant ? p1_we    : p0_we;
  assign sel_addr  = grant ? p1_addr  : p0_addr;
  assign sel_wdata = grant ? p1_wdata : p0_wdata;
  assign sel_be    = grant ? p1_be    : p0_be;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    we_d     = we_q;
    port_d   = port_q;
    a_d      = a_q;
    d_o_d    = d_o_q;
    d_oe_d   = d_oe_q;
    ce_n_d   = ce_n_q;
    oe_n_d   = oe_n_q;
    we_n_d   = we_n_q;
    lb_n_d   = lb_n_q;
    ub_n_d   = ub_n_q;
    ack0_d   = 1'b0;
    ack1_d   = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
`ifndef SRAM_ARB_PRIORITY_EN
    last_d   = last_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (p0_req || p1_req) begin
          state_d = StSetup;
          we_d    = sel_we;
          port_d  = grant;
`ifndef SRAM_ARB_PRIORITY_EN
          last_d  = grant;
`endif
          // Pins for SETUP are loaded here so they are valid right after this edge.
          a_d     = sel_addr;
          ce_n_d  = 1'b0;
          if (sel_we) begin
            d_o_d  = sel_wdata;
            d_oe_d = 1'b1;
            lb_n_d = ~sel_be[0];
            ub_n_d = ~sel_be[1];
          end else begin
            d_oe_d = 1'b0;
            lb_n_d = 1'b0;
            ub_n_d = 1'b0;
          end
        end
      end
      StSetup: begin
        state_d = StAccess;
        cnt_d   = 4'(WAIT_CYCLES - 1);
        if (we_q) we_n_d = 1'b0;
        else      oe_n_d = 1'b0;
      end
      StAccess: begin
        if (cnt_q == 4'd0) begin
          state_d = StHold;
          we_n_d  = 1'b1;
          oe_n_d  = 1'b1;
          if (port_q) ack1_d = 1'b1;
          else        ack0_d = 1'b1;
          if (!we_q) begin
            if (port_q) rdata1_d = sram_d_i;
            else        rdata0_d = sram_d_i;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StHold: begin
        state_d = StIdle;
        ce_n_d  = 1'b1;
        lb_n_d  = 1'b1;
        ub_n_d  = 1'b1;
        d_oe_d  = 1'b0;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_100mhz or negedge resetn) begin
    if (!resetn) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      port_q   <= 1'b0;
      a_q      <= 16'h0000;
      d_o_q    <= 16'h0000;
      d_oe_q   <= 1'b0;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      lb_n_q   <= 1'b1;
      ub_n_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= 16'h0000;
      rdata1_q <= 16'h0000;
`ifndef SRAM_ARB_PRIORITY_EN
      last_q   <= 1'b1;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      we_q     <= we_d;
      port_q   <= port_d;
      a_q      <= a_d;
      d_o_q    <= d_o_d;
      d_oe_q   <= d_oe_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      lb_n_q   <= lb_n_d;
      ub_n_q   <= ub_n_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
`ifndef SRAM_ARB_PRIORITY_EN
      last_q   <= last_d;
`endif
    end
  end

  assign busy      = (state_q != StIdle);
  assign p0_ack    = ack0_q;
  assign p1_ack    = ack1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign sram_a    = a_q;
  assign sram_d_o  = d_o_q;
  assign sram_d_oe = d_oe_q;
  assign sram_ce_n = ce_n_q;
  assign sram_oe_n = oe_n_q;
  assign sram_we_n = we_n_q;
  assign sram_lb_n = lb_n_q;
  assign sram_ub_n = ub_n_q;

endmodule

// File: tb/tb_sram_arbiter.sv
// Testbench for sram_arbiter (WAIT_CYCLES = 2) with a behavioural asynchronous SRAM model.
module tb_sram_arbiter;

  logic        clk_100mhz = 1'b0;
  logic        resetn;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [1:0]  p0_be, p1_be;
  logic        p0_ack, p1_ack, busy;
  logic [15:0] p0_rdata, p1_rdata;
  logic [15:0] sram_a, sram_d_o, sram_d_i;
  logic        sram_d_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n;

  int errors = 0;
  int checks = 0;

  always #5 clk_100mhz = ~clk_100mhz;

  sram_arbiter #(.WAIT_CYCLES(2)) dut (
    .clk_100mhz (clk_100mhz),
    .resetn     (resetn),
    .p0_req     (p0_req),
    .p0_we      (p0_we),
    .p0_addr    (p0_addr),
    .p0_wdata   (p0_wdata),
    .p0_be      (p0_be),
    .p0_ack     (p0_ack),
    .p0_rdata   (p0_rdata),
    .p1_req     (p1_req),
    .p1_we      (p1_we),
    .p1_addr    (p1_addr),
    .p1_wdata   (p1_wdata),
    .p1_be      (p1_be),
    .p1_ack     (p1_ack),
    .p1_rdata   (p1_rdata),
    .busy       (busy),
    .sram_a     (sram_a),
    .sram_d_o   (sram_d_o),
    .sram_d_oe  (sram_d_oe),
    .sram_d_i   (sram_d_i),
    .sram_ce_n  (sram_ce_n),
    .sram_oe_n  (sram_oe_n),
    .sram_we_n  (sram_we_n),
    .sram_lb_n  (sram_lb_n),
    .sram_ub_n  (sram_ub_n)
  );

  // Asynchronous SRAM: reads while CE and OE are low, writes latched on the WE rising edge.
  logic [15:0] mem [0:65535];
  assign sram_d_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_a] : 16'h0000;
  always @(posedge sram_we_n) begin
    if (sram_ce_n === 1'b0) begin
      if (!sram_lb_n) mem[sram_a][7:0]  <= sram_d_o[7:0];
      if (!sram_ub_n) mem[sram_a][15:8] <= sram_d_o[15:8];
    end
  end

  task automatic tick;
    @(posedge clk_100mhz);
    #1;
  endtask

  // Runs one transaction on a port; reports ack, read data and the SETUP-cycle {ub_n, lb_n}.
  task automatic do_access(input int port, input logic we, input logic [15:0] addr,
                           input logic [15:0] wdata, input logic [1:0] be,
                           output logic [15:0] rd, output logic got_ack,
                           output logic [1:0] setup_bytes);
    got_ack = 1'b0;
    rd = 16'h0000;
    setup_bytes = 2'b11;
    if (port == 0) begin
      p0_we = we; p0_addr = addr; p0_wdata = wdata; p0_be = be; p0_req = 1'b1;
    end else begin
      p1_we = we; p1_addr = addr; p1_wdata = wdata; p1_be = be; p1_req = 1'b1;
    end
    for (int c = 0; c < 20 && !got_ack; c++) begin
      tick();
      if (c == 0) setup_bytes = {sram_ub_n, sram_lb_n};
      if (port == 0 && p0_ack) begin
        got_ack = 1'b1; rd = p0_rdata; p0_req = 1'b0;
      end else if (port == 1 && p1_ack) begin
        got_ack = 1'b1; rd = p1_rdata; p1_req = 1'b0;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    tick();
  endtask

  task automatic test_reset;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    tick();
    tick();
    checks++; if ({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n} !== 5'b11111) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 11111",
                         {sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n});
    end
    checks++; if (sram_d_oe !== 1'b0) begin
      errors++; $display("FAIL reset_d_oe: got %b expected 0", sram_d_oe);
    end
    checks++; if (sram_a !== 16'h0000 || sram_d_o !== 16'h0000) begin
      errors++; $display("FAIL reset_a_d: got a=%h d_o=%h expected 0000/0000", sram_a, sram_d_o);
    end
    checks++; if ({p0_ack, p1_ack, busy} !== 3'b000) begin
      errors++; $display("FAIL reset_ack_busy: got %b expected 000", {p0_ack, p1_ack, busy});
    end
    checks++; if (p0_rdata !== 16'h0000 || p1_rdata !== 16'h0000) begin
      errors++; $display("FAIL reset_rdata: got %h/%h expected 0000/0000", p0_rdata, p1_rdata);
    end
    resetn = 1'b1;
    tick();
  endtask

  task automatic test_write;
    // Index i = cycle after request-sample edge k + i; bit i of each vector.
    logic [4:0] exp_we_n, exp_ce_n, exp_ack, exp_busy, exp_bytes_n;
    exp_we_n = 5'b11001; exp_ce_n = 5'b10000; exp_ack = 5'b01000;
    exp_busy = 5'b01111; exp_bytes_n = 5'b10000;
    p0_we = 1'b1; p0_addr = 16'h1234; p0_wdata = 16'hBEEF; p0_be = 2'b11; p0_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (sram_we_n !== exp_we_n[i] || sram_oe_n !== 1'b1) begin
        errors++; $display("FAIL wr_we_oe[%0d]: got we_n=%b oe_n=%b expected %b/1", i,
                           sram_we_n, sram_oe_n, exp_we_n[i]);
      end
      checks++; if (sram_ce_n !== exp_ce_n[i] || sram_lb_n !== exp_bytes_n[i] ||
                    sram_ub_n !== exp_bytes_n[i]) begin
        errors++; $display("FAIL wr_ce_bytes[%0d]: got ce_n=%b lb_n=%b ub_n=%b expected %b/%b/%b",
                           i, sram_ce_n, sram_lb_n, sram_ub_n, exp_ce_n[i], exp_bytes_n[i],
                           exp_bytes_n[i]);
      end
      checks++; if (sram_a !== 16'h1234 || sram_d_o !== 16'hBEEF ||
                    sram_d_oe !== exp_busy[i]) begin
        errors++; $display("FAIL wr_bus[%0d]: got a=%h d_o=%h oe=%b expected 1234/beef/%b", i,
                           sram_a, sram_d_o, sram_d_oe, exp_busy[i]);
      end
      checks++; if (p0_ack !== exp_ack[i] || p1_ack !== 1'b0 || busy !== exp_busy[i]) begin
        errors++; $display("FAIL wr_ack[%0d]: got p0=%b p1=%b busy=%b expected %b/0/%b", i,
                           p0_ack, p1_ack, busy, exp_ack[i], exp_busy[i]);
      end
      if (i == 3) p0_req = 1'b0;
    end
    checks++; if (mem[16'h1234] !== 16'hBEEF) begin
      errors++; $display("FAIL wr_mem: got %h expected beef", mem[16'h1234]);
    end
  endtask

  task automatic test_read;
    logic [4:0] exp_oe_n, exp_ack;
    exp_oe_n = 5'b11001; exp_ack = 5'b01000;
    p1_we = 1'b0; p1_addr = 16'h1234; p1_wdata = 16'h0000; p1_be = 2'b00; p1_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++; if (sram_oe_n !== exp_oe_n[i] || sram_we_n !== 1'b1 || sram_d_oe !== 1'b0) begin
        errors++; $display("FAIL rd_ctrl[%0d]: got oe_n=%b we_n=%b d_oe=%b expected %b/1/0", i,
                           sram_oe_n, sram_we_n, sram_d_oe, exp_oe_n[i]);
      end
      checks++; if (p1_ack !== exp_ack[i] || p0_ack !== 1'b0) begin
        errors++; $display("FAIL rd_ack[%0d]: got p1=%b p0=%b expected %b/0", i, p1_ack, p0_ack,
                           exp_ack[i]);
      end
      if (i >= 3) begin
        checks++; if (p1_rdata !== 16'hBEEF) begin
          errors++; $display("FAIL rd_data[%0d]: got %h expected beef", i, p1_rdata);
        end
      end
      if (i == 3) p1_req = 1'b0;
    end
  endtask

  task automatic test_byte_enable;
    logic [15:0] rd;
    logic        ok;
    logic [1:0]  bytes_n;
    do_access(0, 1'b1, 16'h1234, 16'hAA55, 2'b01, rd, ok, bytes_n);
    checks++; if (ok !== 1'b1 || bytes_n !== 2'b10) begin
      errors++; $display("FAIL be01_write: got ack=%b ub/lb_n=%b expected 1/10", ok, bytes_n);
    end
    do_access(1, 1'b0, 16'h1234, 16'h0000, 2'b00, rd, ok, bytes_n);
    checks++; if (ok !== 1'b1 || rd !== 16'hBE55) begin
      errors++; $display("FAIL be01_read: got ack=%b data=%h expected 1/be55", ok, rd);
    end
    do_access(0, 1'b1, 16'h1234, 16'hFFFF, 2'b00, rd, ok, bytes_n);
    checks++; if (ok !== 1'b1 || bytes_n !== 2'b11) begin
      errors++; $display("FAIL be00_write: got ack=%b ub/lb_n=%b expected 1/11", ok, bytes_n);
    end
    do_access(0, 1'b0, 16'h1234, 16'h0000, 2'b00, rd, ok, bytes_n);
    checks++; if (ok !== 1'b1 || rd !== 16'hBE55 || p0_rdata !== 16'hBE55) begin
      errors++; $display("FAIL be00_read: got ack=%b data=%h held=%h expected 1/be55/be55", ok,
                         rd, p0_rdata);
    end
  endtask

  task automatic test_back_to_back;
    int p0_cnt = 0;
    int p1_cnt = 0;
    logic exp0, exp1;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    tick();
    p0_we = 1'b1; p0_addr = 16'h0010; p0_wdata = 16'h1111; p0_be = 2'b11;
    p1_we = 1'b1; p1_addr = 16'h0020; p1_wdata = 16'h2222; p1_be = 2'b11;
    p0_req = 1'b1; p1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
`ifdef SRAM_ARB_PRIORITY_EN
      exp0 = (i == 3 || i == 8 || i == 13 || i == 18);
      exp1 = 1'b0;
`else
      exp0 = (i == 3 || i == 13);
      exp1 = (i == 8 || i == 18);
`endif
      checks++; if (p0_ack !== exp0 || p1_ack !== exp1) begin
        errors++; $display("FAIL b2b_ack[%0d]: got p0=%b p1=%b expected %b/%b", i, p0_ack,
                           p1_ack, exp0, exp1);
      end
      if (p0_ack === 1'b1) p0_cnt++;
      if (p1_ack === 1'b1) p1_cnt++;
    end
    p0_req = 1'b0; p1_req = 1'b0;
    tick();
`ifdef SRAM_ARB_PRIORITY_EN
    checks++; if (p0_cnt != 4 || p1_cnt != 0) begin
      errors++; $display("FAIL b2b_count: got %0d/%0d expected 4/0", p0_cnt, p1_cnt);
    end
`else
    checks++; if (p0_cnt != 2 || p1_cnt != 2) begin
      errors++; $display("FAIL b2b_count: got %0d/%0d expected 2/2", p0_cnt, p1_cnt);
    end
`endif
    checks++; if (busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_reset_mid_access;
    logic [15:0] rd;
    logic        ok;
    logic [1:0]  bytes_n;
    p1_we = 1'b1; p1_addr = 16'h0300; p1_wdata = 16'h5A5A; p1_be = 2'b11; p1_req = 1'b1;
    tick();
    tick();
    checks++; if (sram_we_n !== 1'b0) begin
      errors++; $display("FAIL mid_access_we: got we_n=%b expected 0", sram_we_n);
    end
    #2 resetn = 1'b0;
    #1;
    checks++; if (sram_we_n !== 1'b1 || sram_ce_n !== 1'b1 || sram_d_oe !== 1'b0) begin
      errors++; $display("FAIL mid_async: got we_n=%b ce_n=%b d_oe=%b expected 1/1/0",
                         sram_we_n, sram_ce_n, sram_d_oe);
    end
    checks++; if (busy !== 1'b0 || sram_a !== 16'h0000 || sram_d_o !== 16'h0000) begin
      errors++; $display("FAIL mid_values: got busy=%b a=%h d_o=%h expected 0/0000/0000", busy,
                         sram_a, sram_d_o);
    end
    p1_req = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (p1_ack !== 1'b0 || busy !== 1'b0) begin
        errors++; $display("FAIL mid_no_ack[%0d]: got ack=%b busy=%b expected 0/0", i, p1_ack,
                           busy);
      end
    end
    resetn = 1'b1;
    tick();
    do_access(1, 1'b0, 16'h1234, 16'h0000, 2'b00, rd, ok, bytes_n);
    checks++; if (ok !== 1'b1 || rd !== 16'hBE55) begin
      errors++; $display("FAIL mid_restart: got ack=%b data=%h expected 1/be55", ok, rd);
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
    p0_req = 1'b0; p0_we = 1'b0; p0_addr = 16'h0; p0_wdata = 16'h0; p0_be = 2'b00;
    p1_req = 1'b0; p1_we = 1'b0; p1_addr = 16'h0; p1_wdata = 16'h0; p1_be = 2'b00;
    test_reset();
    test_write();
    test_read();
    test_byte_enable();
    test_back_to_back();
    test_reset_mid_access();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
